// File: rtl/vexriscv_membus_arbiter.sv
// ---------------------------------------------------------------------------
// vexriscv_membus_arbiter
//
// Shares one memory port between the VexRiscv simple iBus and dBus.
// Commands are arbitrated round-robin. Once a requester is granted and the
// memory stalls, the grant stays locked to that requester until its command
// is accepted. Read responses return in order. A small FIFO of source tags
// routes each response back to the side that issued the read. Writes get no
// response.
//
// Handshake: a command transfers on a cycle where mem_cmd_valid and
// mem_cmd_ready are both high ("fire"). The granted side's *_cmd_ready is
// that same fire, so a command passes through in zero cycles. A requester
// must keep valid and payload stable until its ready is seen. Responses are
// single-cycle strobes with no back-pressure.
//
// Ports
//   clock, resetn                      clock and synchronous active-low reset
//   iBus_cmd_* / iBus_rsp_*            instruction fetch command and response
//   dBus_cmd_* / dBus_rsp_*            data command and load response
//   mem_cmd_* / mem_rsp_*              shared memory-side port
//   pending_count                      reads issued but not yet answered
//   orphan_rsp                         sticky: a response came with no read pending
//   arb_state                          debug view of the arbiter FSM state
// ---------------------------------------------------------------------------
module vexriscv_membus_arbiter #(
   parameter int PENDING_DEPTH = 4,
   parameter int CNT_W         = 3
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              iBus_cmd_valid,
   output logic              iBus_cmd_ready,
   input  logic [31:0]       iBus_cmd_payload_pc,
   output logic              iBus_rsp_valid,
   output logic [31:0]       iBus_rsp_payload_inst,
   output logic              iBus_rsp_payload_error,
   input  logic              dBus_cmd_valid,
   output logic              dBus_cmd_ready,
   input  logic              dBus_cmd_payload_wr,
   input  logic [31:0]       dBus_cmd_payload_address,
   input  logic [31:0]       dBus_cmd_payload_data,
   input  logic [1:0]        dBus_cmd_payload_size,
   output logic              dBus_rsp_ready,
   output logic [31:0]       dBus_rsp_data,
   output logic              dBus_rsp_error,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_wr,
   output logic [31:0]       mem_cmd_addr,
   output logic [31:0]       mem_cmd_data,
   output logic [3:0]        mem_cmd_mask,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data,
   input  logic              mem_rsp_error,
   output logic [CNT_W-1:0]  pending_count,
   output logic              orphan_rsp,
   output logic [1:0]        arb_state
);

   localparam int PTR_W = $clog2(PENDING_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD_I = 2'd1,
      ST_HOLD_D = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic                     last_d_q, last_d_d;   // 1: dBus was the last side to fire
   logic [PENDING_DEPTH-1:0] tag_q, tag_d;         // 1: read came from dBus
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     orphan_q, orphan_d;

   logic grant_d_sel;   // 1: dBus owns the memory port this cycle
   logic gnt_valid;
   logic gnt_wr;
   logic fifo_full;
   logic fire;
   logic push;
   logic pop;
   logic head_tag;
   logic [3:0] d_mask;

   // Grant selection. In IDLE a contended cycle goes to the side that did
   // not fire last; a locked grant ignores the other requester entirely.
   always_comb begin
      grant_d_sel = 1'b0;
      case (state_q)
         ST_HOLD_I: grant_d_sel = 1'b0;
         ST_HOLD_D: grant_d_sel = 1'b1;
         default: begin
            if (iBus_cmd_valid && dBus_cmd_valid) grant_d_sel = ~last_d_q;
            else                                  grant_d_sel = dBus_cmd_valid;
         end
      endcase
   end

   always_comb begin
      d_mask = 4'hF;
      case (dBus_cmd_payload_size)
         2'd0:    d_mask = 4'b0001 << dBus_cmd_payload_address[1:0];
         2'd1:    d_mask = dBus_cmd_payload_address[1] ? 4'b1100 : 4'b0011;
         default: d_mask = 4'hF;
      endcase
   end

   assign gnt_valid = grant_d_sel ? dBus_cmd_valid : iBus_cmd_valid;
   assign gnt_wr    = grant_d_sel & dBus_cmd_payload_wr;
   assign fifo_full = (count_q == CNT_W'(PENDING_DEPTH));

   // Full FIFO stalls reads only, and uses the registered count so a pop in
   // the same cycle does not open a slot combinationally.
   assign mem_cmd_valid = gnt_valid & ~(fifo_full & ~gnt_wr);
   assign fire          = mem_cmd_valid & mem_cmd_ready;
   assign iBus_cmd_ready = fire & ~grant_d_sel;
   assign dBus_cmd_ready = fire &  grant_d_sel;

   assign mem_cmd_wr   = gnt_wr;
   assign mem_cmd_addr = grant_d_sel ? dBus_cmd_payload_address : iBus_cmd_payload_pc;
   assign mem_cmd_data = grant_d_sel ? dBus_cmd_payload_data : 32'h0;
   assign mem_cmd_mask = grant_d_sel ? d_mask : 4'hF;

   assign push     = fire & ~gnt_wr;
   assign pop      = mem_rsp_valid & (count_q != '0);
   assign head_tag = tag_q[rd_ptr_q];

   assign iBus_rsp_valid         = pop & ~head_tag;
   assign iBus_rsp_payload_inst  = mem_rsp_data;
   assign iBus_rsp_payload_error = mem_rsp_error;
   assign dBus_rsp_ready         = pop &  head_tag;
   assign dBus_rsp_data          = mem_rsp_data;
   assign dBus_rsp_error         = mem_rsp_error;

   assign pending_count = count_q;
   assign orphan_rsp    = orphan_q;
   assign arb_state     = state_q;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      orphan_d = orphan_q | (mem_rsp_valid & (count_q == '0));

      case (state_q)
         ST_IDLE: begin
            if (mem_cmd_valid && !mem_cmd_ready)
               state_d = grant_d_sel ? ST_HOLD_D : ST_HOLD_I;
         end
         ST_HOLD_I, ST_HOLD_D: begin
            if (fire) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (fire) last_d_d = grant_d_sel;

      if (push) begin
         tag_d[wr_ptr_q] = grant_d_sel;
         wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         last_d_q <= 1'b1;
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         tag_q    <= tag_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         orphan_q <= orphan_d;
      end
   end

endmodule

// File: tb/tb_vexriscv_membus_arbiter.sv
module tb_vexriscv_membus_arbiter;

   localparam int DEPTH = 4;

   logic        clock;
   logic        resetn;
   logic        iv;
   logic        i_ready;
   logic [31:0] pc;
   logic        i_rsp;
   logic [31:0] i_inst;
   logic        i_err;
   logic        dv;
   logic        d_ready;
   logic        dwr;
   logic [31:0] daddr;
   logic [31:0] ddata;
   logic [1:0]  dsize;
   logic        d_rsp;
   logic [31:0] d_data;
   logic        d_err;
   logic        m_valid;
   logic        mready;
   logic        m_wr;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   logic [3:0]  m_mask;
   logic        rv;
   logic [31:0] rdata;
   logic        rerr;
   logic [2:0]  pend;
   logic        orphan;
   logic [1:0]  arb_state;

   int tests_run;
   int tests_failed;

   vexriscv_membus_arbiter #(.PENDING_DEPTH(DEPTH), .CNT_W(3)) dut (
      .clock(clock), .resetn(resetn),
      .iBus_cmd_valid(iv), .iBus_cmd_ready(i_ready), .iBus_cmd_payload_pc(pc),
      .iBus_rsp_valid(i_rsp), .iBus_rsp_payload_inst(i_inst), .iBus_rsp_payload_error(i_err),
      .dBus_cmd_valid(dv), .dBus_cmd_ready(d_ready), .dBus_cmd_payload_wr(dwr),
      .dBus_cmd_payload_address(daddr), .dBus_cmd_payload_data(ddata), .dBus_cmd_payload_size(dsize),
      .dBus_rsp_ready(d_rsp), .dBus_rsp_data(d_data), .dBus_rsp_error(d_err),
      .mem_cmd_valid(m_valid), .mem_cmd_ready(mready), .mem_cmd_wr(m_wr),
      .mem_cmd_addr(m_addr), .mem_cmd_data(m_data), .mem_cmd_mask(m_mask),
      .mem_rsp_valid(rv), .mem_rsp_data(rdata), .mem_rsp_error(rerr),
      .pending_count(pend), .orphan_rsp(orphan), .arb_state(arb_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; outputs are checked 2 time units later.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      iv = 0; pc = 0; dv = 0; dwr = 0; daddr = 0; ddata = 0; dsize = 0;
      mready = 0; rv = 0; rdata = 0; rerr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      step();
      step();
      resetn = 1;
   endtask

   // Byte-enable rule for a data access.
   function automatic logic [3:0] ref_mask(input logic [1:0] sz, input logic [1:0] a);
      int lanes;
      int first;
      lanes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      first = (lanes == 4) ? 0 : (int'(a) / lanes) * lanes;
      return 4'(((1 << lanes) - 1) << first);
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      #2;
      tests_run++; if (pend !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", pend); end
      tests_run++; if (orphan !== 1'b0) begin tests_failed++; $display("FAIL reset_orphan: got %0b want 0", orphan); end
      tests_run++; if ({m_valid, i_ready, d_ready, i_rsp, d_rsp} !== 5'b0) begin tests_failed++; $display("FAIL reset_strobes: got %05b want 00000", {m_valid, i_ready, d_ready, i_rsp, d_rsp}); end
      step();
   endtask

   task automatic test_single_fetch();
      do_reset();
      iv = 1; pc = 32'h100; mready = 1;
      #2;
      tests_run++; if ({m_valid, i_ready, d_ready} !== 3'b110) begin tests_failed++; $display("FAIL fetch_fire: got %03b want 110", {m_valid, i_ready, d_ready}); end
      tests_run++; if ({m_wr, m_mask, m_addr, m_data} !== {1'b0, 4'hF, 32'h100, 32'h0}) begin tests_failed++; $display("FAIL fetch_payload: got wr=%0b mask=%0h addr=%0h data=%0h want 0/f/100/0", m_wr, m_mask, m_addr, m_data); end
      step();
      iv = 0; mready = 0; rv = 1; rdata = 32'h13;
      #2;
      tests_run++; if (pend !== 3'd1) begin tests_failed++; $display("FAIL fetch_count: got %0d want 1", pend); end
      tests_run++; if ({i_rsp, d_rsp} !== 2'b10 || i_inst !== 32'h13) begin tests_failed++; $display("FAIL fetch_rsp: got strobes %02b inst %0h want 10 / 13", {i_rsp, d_rsp}, i_inst); end
      step();
      rv = 0;
      #2;
      tests_run++; if (pend !== 3'd0) begin tests_failed++; $display("FAIL fetch_drain: got %0d want 0", pend); end
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      iv = 1; pc = 32'h200; dv = 1; dwr = 1; daddr = 32'h40; ddata = 32'h55; dsize = 2; mready = 1;
      for (int k = 0; k < 4; k++) begin
         #2;
         tests_run++; if ({i_ready, d_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL rr_grant_%0d: got %02b want %02b", k, {i_ready, d_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); end
         step();
      end
      idle_inputs();
      #2;
      tests_run++; if (pend !== 3'd2) begin tests_failed++; $display("FAIL rr_count: got %0d want 2 (stores do not count)", pend); end
      rv = 1;
      for (int k = 0; k < 2; k++) begin
         #2;
         tests_run++; if ({i_rsp, d_rsp} !== 2'b10) begin tests_failed++; $display("FAIL rr_rsp_%0d: got %02b want 10", k, {i_rsp, d_rsp}); end
         step();
      end
      rv = 0;
   endtask

   task automatic test_hold();
      do_reset();
      dv = 1; dwr = 0; daddr = 32'h3; dsize = 0; mready = 0;
      #2;
      tests_run++; if ({m_valid, d_ready, m_mask} !== {2'b10, 4'b1000}) begin tests_failed++; $display("FAIL hold_first: got valid=%0b dready=%0b mask=%04b want 1/0/1000", m_valid, d_ready, m_mask); end
      step();
      iv = 1; pc = 32'h300;
      for (int k = 0; k < 2; k++) begin
         #2;
         tests_run++; if (m_addr !== 32'h3 || {i_ready, d_ready} !== 2'b00) begin tests_failed++; $display("FAIL hold_locked_%0d: got addr=%0h ready=%02b want 3/00", k, m_addr, {i_ready, d_ready}); end
         step();
      end
      mready = 1;
      #2;
      tests_run++; if ({i_ready, d_ready} !== 2'b01 || m_mask !== 4'b1000) begin tests_failed++; $display("FAIL hold_release: got ready=%02b mask=%04b want 01/1000", {i_ready, d_ready}, m_mask); end
      step();
      dv = 0;
      #2;
      tests_run++; if (i_ready !== 1'b1 || m_addr !== 32'h300) begin tests_failed++; $display("FAIL hold_next_i: got ready=%0b addr=%0h want 1/300", i_ready, m_addr); end
      step();
      idle_inputs();
      rv = 1; rdata = 32'h1;
      #2;
      tests_run++; if ({i_rsp, d_rsp} !== 2'b01 || d_data !== 32'h1) begin tests_failed++; $display("FAIL hold_rsp_d: got %02b data %0h want 01/1", {i_rsp, d_rsp}, d_data); end
      step();
      rdata = 32'h2;
      #2;
      tests_run++; if ({i_rsp, d_rsp} !== 2'b10) begin tests_failed++; $display("FAIL hold_rsp_i: got %02b want 10", {i_rsp, d_rsp}); end
      step();
      rv = 0;
   endtask

   task automatic test_fifo_full();
      do_reset();
      iv = 1; mready = 1;
      for (int k = 0; k < 4; k++) begin
         pc = 32'(k * 4);
         step();
      end
      #2;
      tests_run++; if (pend !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d want 4", pend); end
      tests_run++; if ({m_valid, i_ready} !== 2'b00) begin tests_failed++; $display("FAIL full_block: got %02b want 00", {m_valid, i_ready}); end
      step();
      dv = 1; dwr = 1; daddr = 32'h80; ddata = 32'hAB; dsize = 1;
      #2;
      tests_run++; if ({d_ready, m_wr, m_mask} !== {2'b11, 4'b0011}) begin tests_failed++; $display("FAIL full_store: got dready=%0b wr=%0b mask=%04b want 1/1/0011", d_ready, m_wr, m_mask); end
      step();
      dv = 0; rv = 1; rdata = 32'h77;
      #2;
      tests_run++; if ({i_rsp, m_valid} !== 2'b10) begin tests_failed++; $display("FAIL full_pop_no_unblock: got rsp=%0b valid=%0b want 1/0", i_rsp, m_valid); end
      step();
      #2;
      tests_run++; if (pend !== 3'd3) begin tests_failed++; $display("FAIL full_after_pop: got %0d want 3", pend); end
      tests_run++; if ({i_ready, i_rsp} !== 2'b11) begin tests_failed++; $display("FAIL full_push_pop: got %02b want 11", {i_ready, i_rsp}); end
      step();
      iv = 0;
      #2;
      tests_run++; if (pend !== 3'd3) begin tests_failed++; $display("FAIL full_push_pop_count: got %0d want 3", pend); end
      step(); step(); step();
      rv = 0;
      #2;
      tests_run++; if (pend !== 3'd0) begin tests_failed++; $display("FAIL full_drain: got %0d want 0", pend); end
      step();
   endtask

   task automatic test_order();
      logic [31:0] vals [3];
      logic        errs [3];
      logic        side [3];
      vals = '{32'hA, 32'hB, 32'hC};
      errs = '{1'b0, 1'b1, 1'b0};
      side = '{1'b0, 1'b1, 1'b0};
      do_reset();
      mready = 1;
      iv = 1; pc = 32'h10; step();
      iv = 0; dv = 1; dwr = 0; daddr = 32'h20; dsize = 2; step();
      dv = 0; iv = 1; pc = 32'h30; step();
      idle_inputs();
      #2;
      tests_run++; if (pend !== 3'd3) begin tests_failed++; $display("FAIL order_count: got %0d want 3", pend); end
      for (int k = 0; k < 3; k++) begin
         rv = 1; rdata = vals[k]; rerr = errs[k];
         #2;
         if (side[k]) begin
            tests_run++; if ({i_rsp, d_rsp} !== 2'b01 || d_data !== vals[k] || d_err !== errs[k]) begin tests_failed++; $display("FAIL order_rsp_%0d: got %02b data %0h err %0b want 01/%0h/%0b", k, {i_rsp, d_rsp}, d_data, d_err, vals[k], errs[k]); end
         end else begin
            tests_run++; if ({i_rsp, d_rsp} !== 2'b10 || i_inst !== vals[k] || i_err !== errs[k]) begin tests_failed++; $display("FAIL order_rsp_%0d: got %02b inst %0h err %0b want 10/%0h/%0b", k, {i_rsp, d_rsp}, i_inst, i_err, vals[k], errs[k]); end
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_orphan();
      do_reset();
      rv = 1; rdata = 32'hDEAD;
      #2;
      tests_run++; if ({i_rsp, d_rsp} !== 2'b00) begin tests_failed++; $display("FAIL orphan_strobes: got %02b want 00", {i_rsp, d_rsp}); end
      step();
      rv = 0;
      #2;
      tests_run++; if (orphan !== 1'b1 || pend !== 3'd0) begin tests_failed++; $display("FAIL orphan_set: got orphan=%0b count=%0d want 1/0", orphan, pend); end
      step();
      #2;
      tests_run++; if (orphan !== 1'b1) begin tests_failed++; $display("FAIL orphan_sticky: got %0b want 1", orphan); end
      iv = 1; pc = 32'h400; mready = 1;
      step();
      idle_inputs();
      resetn = 0;
      step();
      resetn = 1;
      #2;
      tests_run++; if (orphan !== 1'b0 || pend !== 3'd0) begin tests_failed++; $display("FAIL orphan_reset: got orphan=%0b count=%0d want 0/0", orphan, pend); end
      rv = 1;
      #1;
      tests_run++; if ({i_rsp, d_rsp} !== 2'b00) begin tests_failed++; $display("FAIL late_rsp_strobes: got %02b want 00", {i_rsp, d_rsp}); end
      step();
      rv = 0;
      #2;
      tests_run++; if (orphan !== 1'b1) begin tests_failed++; $display("FAIL late_rsp_orphan: got %0b want 1", orphan); end
      step();
   endtask

   // Random traffic against a transaction-level model: a queue of outstanding
   // read owners, the last side served, and which side (if any) holds a stalled
   // command.
   task automatic test_random();
      logic exp_q[$];
      logic m_last_d;
      int   m_hold;      // 0 none, 1 iBus, 2 dBus
      logic m_orphan;
      logic owner, own_valid, own_rd, e_valid, e_fire, e_irsp, e_drsp;
      logic [31:0] e_addr;
      logic [3:0]  e_mask;
      do_reset();
      exp_q.delete();
      m_last_d = 1; m_hold = 0; m_orphan = 0;
      for (int c = 0; c < 600; c++) begin
         if (m_hold != 1) begin iv = 1'($urandom_range(0, 1)); pc = $urandom; end
         if (m_hold != 2) begin
            dv = 1'($urandom_range(0, 1)); dwr = 1'($urandom_range(0, 1));
            daddr = $urandom; ddata = $urandom; dsize = 2'($urandom_range(0, 3));
         end
         mready = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 2) == 0); rdata = $urandom; rerr = 1'($urandom_range(0, 1));
         #2;
         if (m_hold == 1)      owner = 0;
         else if (m_hold == 2) owner = 1;
         else if (iv && dv)    owner = !m_last_d;
         else                  owner = dv;
         own_valid = owner ? dv : iv;
         own_rd    = owner ? !dwr : 1'b1;
         e_valid   = own_valid && !(exp_q.size() == DEPTH && own_rd);
         e_fire    = e_valid && mready;
         e_irsp    = rv && exp_q.size() > 0 && exp_q[0] == 1'b0;
         e_drsp    = rv && exp_q.size() > 0 && exp_q[0] == 1'b1;
         e_addr    = owner ? daddr : pc;
         e_mask    = owner ? ref_mask(dsize, daddr[1:0]) : 4'hF;
         tests_run++; if ({m_valid, i_ready, d_ready} !== {e_valid, e_fire && !owner, e_fire && owner}) begin tests_failed++; $display("FAIL rnd_cmd c%0d: got %03b want %03b", c, {m_valid, i_ready, d_ready}, {e_valid, e_fire && !owner, e_fire && owner}); end
         if (e_valid) begin
            tests_run++; if ({m_addr, m_mask, m_wr} !== {e_addr, e_mask, !own_rd}) begin tests_failed++; $display("FAIL rnd_payload c%0d: got addr=%0h mask=%0h wr=%0b want %0h/%0h/%0b", c, m_addr, m_mask, m_wr, e_addr, e_mask, !own_rd); end
         end
         tests_run++; if ({i_rsp, d_rsp} !== {e_irsp, e_drsp}) begin tests_failed++; $display("FAIL rnd_rsp c%0d: got %02b want %02b", c, {i_rsp, d_rsp}, {e_irsp, e_drsp}); end
         if (e_irsp || e_drsp) begin
            tests_run++; if ((e_irsp ? {i_inst, i_err} : {d_data, d_err}) !== {rdata, rerr}) begin tests_failed++; $display("FAIL rnd_rsp_data c%0d: got %0h want %0h", c, e_irsp ? {i_inst, i_err} : {d_data, d_err}, {rdata, rerr}); end
         end
         tests_run++; if (pend !== 3'(exp_q.size()) || orphan !== m_orphan) begin tests_failed++; $display("FAIL rnd_status c%0d: got count=%0d orphan=%0b want %0d/%0b", c, pend, orphan, exp_q.size(), m_orphan); end
         if (rv) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else m_orphan = 1;
         end
         if (e_fire && own_rd) exp_q.push_back(owner);
         if (e_fire) m_last_d = owner;
         if (m_hold == 0 && e_valid && !mready) m_hold = owner ? 2 : 1;
         else if (m_hold != 0 && e_fire)       m_hold = 0;
         step();
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      tests_run = 0;
      tests_failed = 0;
      resetn = 0;
      idle_inputs();
      @(negedge clock);
      test_reset();
      test_single_fetch();
      test_round_robin();
      test_hold();
      test_fifo_full();
      test_order();
      test_orphan();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
